// File: rtl/gpr_dbg_access.sv
`default_nettype none
// ============================================================================
// Module      : gpr_dbg_access
// Description : Arbitrates GPR register-file access between core writeback
//               and Debug Module abstract commands. A debug command is
//               accepted in IDLE, waits (bounded) for the core to halt, then
//               performs one write through the rd port or one read through
//               the rs1 port, and holds a response until it is consumed.
//               Outside the EXEC state all core traffic passes straight
//               through to the register file.
// Ports       : clk, rst_n (async active-low)
//               core_halted                           - core halted flag
//               wb_addr_rd/wb_data_rd/wb_reg_WEn      - core writeback in
//               dec_addr_rs1                          - decode rs1 address in
//               rf_addr_rd/rf_data_rd/rf_reg_WEn      - to RF write port
//               rf_addr_rs1 / rf_data_rs1             - RF rs1 read port
//               dbg_req/dbg_ready/dbg_write/dbg_regno/dbg_wdata - command
//               dbg_rsp_valid/dbg_rsp_ready/dbg_rdata/dbg_err   - response
// Config      : GPR_DBG_X0_WRITE_ERR_EN - when defined, a debug write to x0
//               is rejected with dbg_err=1 and never reaches EXEC.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_dbg_access #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int HALT_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_halted,
  input  logic [REG_AW-1:0] wb_addr_rd,
  input  logic [XLEN-1:0]   wb_data_rd,
  input  logic              wb_reg_WEn,
  input  logic [REG_AW-1:0] dec_addr_rs1,
  output logic [REG_AW-1:0] rf_addr_rd,
  output logic [XLEN-1:0]   rf_data_rd,
  output logic              rf_reg_WEn,
  output logic [REG_AW-1:0] rf_addr_rs1,
  input  logic [XLEN-1:0]   rf_data_rs1,
  input  logic              dbg_req,
  output logic              dbg_ready,
  input  logic              dbg_write,
  input  logic [REG_AW-1:0] dbg_regno,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic              dbg_err
);

  // Wide enough to hold HALT_WAIT-1 for any HALT_WAIT >= 1.
  localparam int c_CNT_W = $clog2(HALT_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALT_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_HALT = 2'd1,
    S_EXEC      = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic [REG_AW-1:0]   r_regno;
  logic [XLEN-1:0]     r_wdata;
  logic [XLEN-1:0]     r_rdata;
  logic                r_err;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                w_accept;
  logic                w_x0_err;
  logic                w_timeout;
  logic                w_dbg_rd;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and register-file port muxing
  // --------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_x0_err      = 1'b0;
    w_timeout     = 1'b0;
    w_dbg_rd      = 1'b0;
    dbg_ready     = 1'b0;
    dbg_rsp_valid = 1'b0;
    rf_addr_rd    = wb_addr_rd;
    rf_data_rd    = wb_data_rd;
    rf_reg_WEn    = wb_reg_WEn;
    rf_addr_rs1   = dec_addr_rs1;

    case (r_state)
      S_IDLE: begin
        dbg_ready = 1'b1;
        if (dbg_req) begin
          w_accept = 1'b1;
`ifdef GPR_DBG_X0_WRITE_ERR_EN
          w_x0_err = dbg_write && (dbg_regno == '0);
`else
          w_x0_err = 1'b0;
`endif
          if (w_x0_err) begin
            w_next = S_RESP;
          end else if (core_halted) begin
            w_next = S_EXEC;
          end else begin
            w_next = S_WAIT_HALT;
          end
        end
      end

      S_WAIT_HALT: begin
        if (core_halted) begin
          w_next = S_EXEC;
        end else if (r_cnt == c_CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end

      S_EXEC: begin
        if (r_write) begin
          if (r_regno == '0) begin
            // x0 is hardwired: drop the write without touching the RF.
            w_next = S_RESP;
          end else if (!wb_reg_WEn) begin
            rf_reg_WEn = 1'b1;
            rf_addr_rd = r_regno;
            rf_data_rd = r_wdata;
            w_next     = S_RESP;
          end
          // Otherwise core writeback owns the port; retry next cycle.
        end else begin
          rf_addr_rs1 = r_regno;
          w_dbg_rd    = 1'b1;
          w_next      = S_RESP;
        end
      end

      S_RESP: begin
        dbg_rsp_valid = 1'b1;
        if (dbg_rsp_ready) begin
          w_next = S_IDLE;
        end
      end

      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch, halt-wait counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_regno <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_write <= dbg_write;
        r_regno <= dbg_regno;
        r_wdata <= dbg_wdata;
        r_rdata <= '0;
        r_err   <= w_x0_err;
        r_cnt   <= '0;
      end
      if (r_state == S_WAIT_HALT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_dbg_rd) begin
        r_rdata <= (r_regno == '0) ? '0 : rf_data_rs1;
      end
    end
  end

  assign dbg_rdata = r_rdata;
  assign dbg_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gpr_dbg_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_dbg_access
// Description : Directed self-checking bench for gpr_dbg_access with a
//               behavioural register file and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_dbg_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_halted = 1'b1;
  logic [4:0]  wb_addr_rd = '0;
  logic [31:0] wb_data_rd = '0;
  logic        wb_reg_WEn = 1'b0;
  logic [4:0]  dec_addr_rs1 = '0;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic        rf_reg_WEn;
  logic [4:0]  rf_addr_rs1;
  logic [31:0] rf_data_rs1;
  logic        dbg_req = 1'b0;
  logic        dbg_ready;
  logic        dbg_write = 1'b0;
  logic [4:0]  dbg_regno = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready = 1'b1;
  logic [31:0] dbg_rdata;
  logic        dbg_err;

  gpr_dbg_access #(.XLEN(32), .REG_AW(5), .HALT_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .core_halted(core_halted),
    .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd), .wb_reg_WEn(wb_reg_WEn),
    .dec_addr_rs1(dec_addr_rs1),
    .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd), .rf_reg_WEn(rf_reg_WEn),
    .rf_addr_rs1(rf_addr_rs1), .rf_data_rs1(rf_data_rs1),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_write(dbg_write),
    .dbg_regno(dbg_regno), .dbg_wdata(dbg_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err)
  );

  always #5 clk = ~clk;

  // Behavioural register file: x0 reads as zero, writes on the rising edge.
  logic [31:0] rf_mem [0:31];
  always @(posedge clk) begin
    if (rf_reg_WEn && rf_addr_rd != 5'd0) rf_mem[rf_addr_rd] <= rf_data_rd;
  end
  assign rf_data_rs1 = (rf_addr_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_addr_rs1];

  // Writes that did not come from core writeback must be debug writes.
  int         dbg_wen_cnt = 0;
  logic [4:0] last_wen_addr = '0;
  always @(posedge clk) begin
    if (rf_reg_WEn && !wb_reg_WEn) begin
      dbg_wen_cnt   <= dbg_wen_cnt + 1;
      last_wen_addr <= rf_addr_rd;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command, push its expected response, then wait for and score
  // the response. halt_at/wb_at name the negedge (counted from acceptance)
  // at which core_halted rises / a one-cycle core writeback to x11 occurs.
  task automatic do_cmd(input string tag, input logic w, input logic [4:0] regno,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int halt_at,
                        input int wb_at, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(dbg_ready), 32'd1);
    dbg_req = 1'b1; dbg_write = w; dbg_regno = regno; dbg_wdata = wdata;
    dbg_rsp_ready = (hold == 0);
    @(posedge clk);
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      dbg_req = 1'b0;
      if (n == halt_at) core_halted = 1'b1;
      if (n == wb_at) begin
        wb_reg_WEn = 1'b1; wb_addr_rd = 5'd11; wb_data_rd = 32'h77;
      end else begin
        wb_reg_WEn = 1'b0;
      end
    end while (!dbg_rsp_valid && n < 40);
    e = sb.pop_front();
    chk({tag, ".lat"},   32'(n),       32'(e.lat));
    chk({tag, ".rdata"}, dbg_rdata,    e.rdata);
    chk({tag, ".err"},   32'(dbg_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(dbg_rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, dbg_rdata, e.rdata);
      chk({tag, ".hold_err"},   32'(dbg_err), 32'(e.err));
    end
    dbg_rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  int wc;
  logic exp_x0_err;
  int   exp_x0_lat;

  initial begin
`ifdef GPR_DBG_X0_WRITE_ERR_EN
    exp_x0_err = 1'b1; exp_x0_lat = 1;
`else
    exp_x0_err = 1'b0; exp_x0_lat = 2;
`endif
    #1;
    chk("rst.ready", 32'(dbg_ready), 32'd1);
    chk("rst.rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rst.rdata", dbg_rdata, 32'd0);
    chk("rst.err", 32'(dbg_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Core writeback passes through while idle; preloads x4 = 9.
    @(negedge clk);
    wb_reg_WEn = 1'b1; wb_addr_rd = 5'd4; wb_data_rd = 32'd9; dec_addr_rs1 = 5'd7;
    #1;
    chk("pt.wen", 32'(rf_reg_WEn), 32'd1);
    chk("pt.addr_rd", 32'(rf_addr_rd), 32'd4);
    chk("pt.data_rd", rf_data_rd, 32'd9);
    chk("pt.addr_rs1", 32'(rf_addr_rs1), 32'd7);
    @(negedge clk);
    wb_reg_WEn = 1'b0;

    // Halted read, write/readback.
    do_cmd("rd_x4", 1'b0, 5'd4, 32'd0, 32'd9, 1'b0, 2, 0, 0, 0);
    wc = dbg_wen_cnt;
    do_cmd("wr_x5", 1'b1, 5'd5, 32'hDEADBEEF, 32'd0, 1'b0, 2, 0, 0, 0);
    chk("wr_x5.wen_cnt", 32'(dbg_wen_cnt), 32'(wc + 1));
    chk("wr_x5.wen_addr", 32'(last_wen_addr), 32'd5);
    do_cmd("rd_x5", 1'b0, 5'd5, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0, 0, 0);

    // Never halts: times out after 8 WAIT_HALT cycles with no RF write.
    core_halted = 1'b0;
    wc = dbg_wen_cnt;
    do_cmd("wr_x8_to", 1'b1, 5'd8, 32'h1234, 32'd0, 1'b1, 9, 0, 0, 0);
    chk("wr_x8_to.wen_cnt", 32'(dbg_wen_cnt), 32'(wc));

    // Halt arrives 3 cycles after acceptance.
    do_cmd("wr_x9_late", 1'b1, 5'd9, 32'h55, 32'd0, 1'b0, 5, 3, 0, 0);
    do_cmd("rd_x9", 1'b0, 5'd9, 32'd0, 32'h55, 1'b0, 2, 0, 0, 0);

    // x0 handling.
    wc = dbg_wen_cnt;
    do_cmd("wr_x0", 1'b1, 5'd0, 32'h1, 32'd0, exp_x0_err, exp_x0_lat, 0, 0, 0);
    chk("wr_x0.wen_cnt", 32'(dbg_wen_cnt), 32'(wc));
    do_cmd("rd_x0", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 2, 0, 0, 0);

    // Core writeback collides with the debug write: debug stalls one cycle.
    wc = dbg_wen_cnt;
    do_cmd("wr_x10_conf", 1'b1, 5'd10, 32'hA5, 32'd0, 1'b0, 3, 0, 1, 0);
    chk("conf.core_x11", rf_mem[11], 32'h77);
    chk("conf.wen_cnt", 32'(dbg_wen_cnt), 32'(wc + 1));
    do_cmd("rd_x10", 1'b0, 5'd10, 32'd0, 32'hA5, 1'b0, 2, 0, 0, 0);

    // Response held for 5 cycles.
    do_cmd("rd_x4_hold", 1'b0, 5'd4, 32'd0, 32'd9, 1'b0, 2, 0, 0, 5);

    // Reset in the middle of WAIT_HALT.
    core_halted = 1'b0;
    wc = dbg_wen_cnt;
    @(negedge clk);
    dbg_req = 1'b1; dbg_write = 1'b1; dbg_regno = 5'd12; dbg_wdata = 32'h33;
    @(negedge clk);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("mid_rst.ready", 32'(dbg_ready), 32'd1);
    chk("mid_rst.err", 32'(dbg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    core_halted = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst.rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("post_rst.ready", 32'(dbg_ready), 32'd1);
    chk("post_rst.wen_cnt", 32'(dbg_wen_cnt), 32'(wc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
